tlb_sv32_plru: RTL

- Parametrised successor to the 4-entry Sv32 TLB.
- Fully associative, TLB_ENTRIES deep (power of two), configurable ASID width, 4 MiB superpage and global-bit support.
- Tree-PLRU replacement with an invalid-first victim; full sfence.vma flush semantics.
- Sits between the PTW (update side) and the MMU lookup path. Exports flattened tag/content state for equivalence and distinguisher benches.

---
 rtl/tlb_sv32_plru.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tlb_sv32_plru.sv
// ---------------------------------------------------------------------------
// tlb_sv32_plru
//
// Fully associative Sv32 TLB with TLB_ENTRIES entries (power of two, >= 2).
// It supports configurable ASID width, 4 MiB superpages and global mappings.
// Replacement fills the lowest invalid entry first; once every entry is
// valid, a tree pseudo-LRU picks the victim. sfence.vma flushes can be
// qualified by ASID and/or virtual address.
//
// Ports
//   clk_i                  clock
//   rst_ni                 synchronous active-low reset
//   flush_i                sfence.vma request, single cycle
//   asid_to_be_flushed_i   ASID qualifier for the flush (0 = any ASID)
//   vaddr_to_be_flushed_i  vaddr qualifier for the flush (0 = any address)
//   update_i               refill from the PTW:
//                          {valid, is_4M, vpn[19:0], asid, content[31:0]}
//   lu_access_i            lookup counts as a use for replacement
//   lu_asid_i              lookup ASID
//   lu_vaddr_i             lookup virtual address
//   lu_content_o           PTE of the hit entry, 0 on miss
//   lu_is_4M_o             hit entry is a 4 MiB superpage
//   lu_hit_o               lookup hit
//   port_content_q_o       entry i content at [32*i +: 32]
//   port_tags_q_o          entry i tag at [TAG_W*i +: TAG_W],
//                          tag = {asid, vpn1, vpn0, is_4M, valid}
// ---------------------------------------------------------------------------
module tlb_sv32_plru #(
    parameter int TLB_ENTRIES = 4,
    parameter int ASID_WIDTH  = 1,
    localparam int TAG_W      = ASID_WIDTH + 22
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic [ASID_WIDTH-1:0]          asid_to_be_flushed_i,
    input  logic [31:0]                    vaddr_to_be_flushed_i,
    input  logic [53+ASID_WIDTH:0]         update_i,
    input  logic                           lu_access_i,
    input  logic [ASID_WIDTH-1:0]          lu_asid_i,
    input  logic [31:0]                    lu_vaddr_i,
    output logic [31:0]                    lu_content_o,
    output logic                           lu_is_4M_o,
    output logic                           lu_hit_o,
    output logic [32*TLB_ENTRIES-1:0]      port_content_q_o,
    output logic [TAG_W*TLB_ENTRIES-1:0]   port_tags_q_o
);

    localparam int LVLS  = $clog2(TLB_ENTRIES);
    localparam int IDX_W = LVLS;
    // Index width for the PLRU node vector (TLB_ENTRIES-1 bits)
    localparam int PW    = (TLB_ENTRIES > 2) ? $clog2(TLB_ENTRIES - 1) : 1;

    logic [TAG_W-1:0]       tags_q    [TLB_ENTRIES];
    logic [31:0]            content_q [TLB_ENTRIES];
    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
    // A node bit of 1 sends the victim search to the right subtree.
    logic [TLB_ENTRIES-2:0] plru_q;
    logic [TLB_ENTRIES-2:0] plru_d;

    logic                   upd_valid;
    logic                   upd_is_4m;
    logic [19:0]            upd_vpn;
    logic [ASID_WIDTH-1:0]  upd_asid;
    logic [31:0]            upd_content;

    logic [TLB_ENTRIES-1:0] lu_match;
    logic [TLB_ENTRIES-1:0] flush_sel;
    logic [TLB_ENTRIES-1:0] entry_valid;
    logic                   flush_asid_any;
    logic                   flush_vaddr_any;

    logic [IDX_W-1:0]       hit_idx;
    logic [IDX_W-1:0]       free_idx;
    logic                   free_found;
    logic [IDX_W-1:0]       repl_idx;

    logic                   unused_vaddr_bits;

    assign upd_content = update_i[31:0];
    assign upd_asid    = update_i[32 +: ASID_WIDTH];
    assign upd_vpn     = update_i[32+ASID_WIDTH +: 20];
    assign upd_is_4m   = update_i[52+ASID_WIDTH];
    assign upd_valid   = update_i[53+ASID_WIDTH];

    assign flush_asid_any  = (asid_to_be_flushed_i == '0);
    assign flush_vaddr_any = (vaddr_to_be_flushed_i == '0);

    // Page offset never takes part in translation matching
    assign unused_vaddr_bits = ^lu_vaddr_i[11:0];

    // Follow the node bits from the root down to a leaf
    function automatic logic [IDX_W-1:0] plru_victim(input logic [TLB_ENTRIES-2:0] tree);
        int node;
        node = 0;
        for (int l = 0; l < LVLS; l++) begin
            node = 2 * node + 1 + int'(tree[PW'(node)]);
        end
        return IDX_W'(node - (TLB_ENTRIES - 1));
    endfunction

    // Walk from the leaf up, pointing every ancestor at the other subtree
    function automatic logic [TLB_ENTRIES-2:0] plru_touch(input logic [TLB_ENTRIES-2:0] tree,
                                                          input logic [IDX_W-1:0]       idx);
        int node;
        int parent;
        plru_touch = tree;
        node = int'(idx) + TLB_ENTRIES - 1;
        for (int l = 0; l < LVLS; l++) begin
            parent = (node - 1) / 2;
            plru_touch[PW'(parent)] = ((node % 2) == 1);
            node = parent;
        end
    endfunction

    // Per-entry match against the lookup and against the flush qualifiers.
    // The flush select ignores the valid bit because it only ever clears it.
    always_comb begin : match_logic
        lu_match    = '0;
        flush_sel   = '0;
        entry_valid = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            entry_valid[i] = tags_q[i][0];
            lu_match[i] = tags_q[i][0]
                && ((tags_q[i][TAG_W-1:22] == lu_asid_i) || content_q[i][5])
                && (tags_q[i][21:12] == lu_vaddr_i[31:22])
                && (tags_q[i][1] || (tags_q[i][11:2] == lu_vaddr_i[21:12]));
            flush_sel[i] = (flush_vaddr_any
                    || ((tags_q[i][21:12] == vaddr_to_be_flushed_i[31:22])
                        && (tags_q[i][1] || (tags_q[i][11:2] == vaddr_to_be_flushed_i[21:12]))))
                && (flush_asid_any
                    || ((tags_q[i][TAG_W-1:22] == asid_to_be_flushed_i) && !content_q[i][5]));
        end
    end

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin : hit_select
        lu_hit_o     = 1'b0;
        hit_idx      = '0;
        lu_content_o = '0;
        lu_is_4M_o   = 1'b0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (lu_match[i]) begin
                lu_hit_o     = 1'b1;
                hit_idx      = IDX_W'(i);
                lu_content_o = content_q[i];
                lu_is_4M_o   = tags_q[i][1];
            end
        end
    end

    // Refill target: lowest invalid entry, otherwise the PLRU victim
    always_comb begin : victim_select
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!entry_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        repl_idx = free_found ? free_idx : plru_victim(plru_q);
    end

    // A refill is only a use when it is not dropped by a concurrent flush,
    // and it takes precedence over the lookup use in the same cycle
    always_comb begin : plru_next
        plru_d = plru_q;
        if (upd_valid && !flush_i) begin
            plru_d = plru_touch(plru_q, repl_idx);
        end else if (lu_access_i && lu_hit_o) begin
            plru_d = plru_touch(plru_q, hit_idx);
        end
    end

    always_ff @(posedge clk_i) begin : state_regs
        if (!rst_ni) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tags_q[i]    <= '0;
                content_q[i] <= '0;
            end
            plru_q <= '0;
        end else begin
            if (flush_i) begin
                for (int i = 0; i < TLB_ENTRIES; i++) begin
                    if (flush_sel[i]) begin
                        tags_q[i][0] <= 1'b0;
                    end
                end
            end else if (upd_valid) begin
                tags_q[repl_idx]    <= {upd_asid, upd_vpn, upd_is_4m, 1'b1};
                content_q[repl_idx] <= upd_content;
            end
            plru_q <= plru_d;
        end
    end

    for (genvar g = 0; g < TLB_ENTRIES; g++) begin : g_flat
        assign port_content_q_o[32*g +: 32]   = content_q[g];
        assign port_tags_q_o[TAG_W*g +: TAG_W] = tags_q[g];
    end

endmodule
